uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin controller that shares one `uart_tx` transmitter among `NUM_REQ` requesters, each submitting a fixed-length multi-byte message. It sits between the command/telemetry producers and the transmitter. It latches the granted message, feeds its bytes one at a time through the `tx_start`/`tx_rdy` handshake, and pulses a per-requester `done` when the last byte has finished on the line.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MSG_BYTES`, default 2: payload bytes per message, 1..8.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NUM_REQ: level request per requester; hold until `done[i]`.
- `msg_data`  in  NUM_REQ*MSG_BYTES*8: requester i payload at `[(i+1)*MSG_BYTES*8-1 : i*MSG_BYTES*8]`; byte 0 is the least-significant byte.
- `gnt`  out  NUM_REQ: one-hot, registered; the requester currently being served.
- `done`  out  NUM_REQ: one-cycle pulse on the served requester's bit when its message is complete.
- `busy`  out  1: high whenever not in IDLE.
- `tx_start`  out  1: transmit strobe to `uart_tx`.
- `tx_data`  out  8: byte to `uart_tx`, registered.
- `tx_rdy`  in  1: transmitter idle (from `uart_tx`).

## Operation
- States: IDLE, START, WAIT_LO, WAIT_HI, DONE.
- **IDLE**
  - If `|req`, the round-robin pick selects winner w.
  - On the clock edge: `gnt <= onehot(w)`, all of w's `msg_data` latched into an internal buffer, byte index <= 0, `tx_data <= byte0`, state <= START.
  - If no request, stay in IDLE.
- **START**
  - `tx_start = (state==START) & tx_rdy`, combinational.
  - On the clock edge with `tx_start`, go to WAIT_LO.
  - While `tx_rdy` is low, stay in START; `tx_start` stays 0.
- **WAIT_LO**: stay until `tx_rdy==0`, which is the transmitter accepting the byte, then go to WAIT_HI.
- **WAIT_HI**: stay until `tx_rdy==1`, which is the frame finished. Then:
  - If more bytes remain: index++, `tx_data <=` next byte, go to START.
  - Otherwise go to DONE.
- **DONE**
  - `done <= gnt` for exactly one cycle.
  - `gnt <= 0`.
  - Priority pointer <= (w+1) mod NUM_REQ.
  - Go to IDLE.
- **Round-robin rule**
  - The search starts at the pointer index and proceeds upward with wrap-around; the first asserted `req` wins.
  - The pointer is 0 after reset.
  - Simultaneous requests are served in pointer order. No requester waits more than NUM_REQ-1 messages.
- **Request handling**
  - `req` and `msg_data` are ignored while `busy`. The buffer is frozen after the grant.
  - A `req` still high in the IDLE cycle after `done` is treated as a new request.
- **Byte order**: byte 0 first, then ascending.
- **Byte index** width is `$clog2(MSG_BYTES+1)`, enough for the checksum slot.

## Timing
- **Reset values**: `gnt=0`, `done=0`, `busy=0`, `tx_start=0`, `tx_data=8'h00`, state=IDLE, pointer=0, index=0.
- **Reset mid-message**: the message is abandoned and no `done` is issued. `tx_start` is low in the cycle after `rst`.
- **Grant latency**: `req` high in IDLE at edge t gives `gnt`/`busy` high after edge t. The earliest `tx_start` is the cycle following edge t.
- **Strobe width**: `tx_start` is high for at most one cycle per byte.
- **Transmitter feedback**: `uart_tx` drops `tx_rdy` in the cycle after `tx_start`.
- **Byte spacing**: the next byte's `tx_start` is asserted in the same cycle the controller leaves WAIT_HI→START when `tx_rdy` is high. That gives one cycle of controller overhead per byte beyond the transmitter frame.
- **done timing**: `done` is asserted in the cycle after the last WAIT_HI exit. `busy` drops one cycle later (IDLE).
- **Back-to-back grants**: from IDLE with a pending `req`, the next grant is registered on the following edge.
- **tx_rdy held low**: the controller waits indefinitely in START; there is no timeout.

## Configuration
- **`UART_ARB_CHKSUM_EN`**
  - Defined: after payload byte MSG_BYTES-1, one extra byte is sent. It is the 8-bit wrap-around sum of all payload bytes (carry discarded), computed from the latched buffer.
  - `done` follows completion of the checksum byte.
  - Undefined: exactly MSG_BYTES bytes are sent, and no adder logic exists.

## Structure
- **Package `uart_arb_pkg`**
  - `arb_state_t` enum (IDLE, START, WAIT_LO, WAIT_HI, DONE).
  - Localparam `MAX_REQ=8`.
  - Localparam `MAX_BYTES=8`.
- **Sub-module `rr_pick`**
  - Combinational round-robin selector.
  - Inputs: `req`, `ptr`.
  - Outputs: `valid`, one-hot `win`, encoded `win_idx`.
  - The pointer register stays in the top level.

## Test plan
- **Single request**: `req[2]=1`, `msg_data` bytes `8'hA5,8'h3C`, driving a real `uart_tx`.
  - Expect `gnt=4'b0100` one cycle later.
  - Expect two `tx_start` pulses with `tx_data` A5 then 3C.
  - Expect `done[2]` once, after the second frame's stop bit.
- **Simultaneous requests**: `req=4'b1011` asserted together from reset.
  - Expect service order 0,1,3.
  - Expect exactly one `done` pulse per requester, in that order.
- **Fairness**: `req[0]` and `req[1]` held high continuously; expect grants alternating 0,1,0,1.
- **Stalled transmitter**: stub holds `tx_rdy=0` for 1000 cycles while in START.
  - Expect `tx_start=0` throughout.
  - Expect a single pulse on the cycle `tx_rdy` rises.
- **Reset mid-message**: `rst` asserted during WAIT_HI of byte 0.
  - Expect all outputs at reset values on the next cycle, and no `done`.
  - A new `req[1]` is then served normally.
- **Checksum** (`UART_ARB_CHKSUM_EN` defined): payload `8'hF0,8'h20`; expect a third byte `8'h10` before `done`.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and limits for the round-robin UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LO,
    WAIT_HI,
    DONE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted req at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx
);

  int unsigned k;

  always_comb begin
    valid   = 1'b0;
    win     = '0;
    win_idx = '0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr) + i) % NUM_REQ;
      if (!valid && req[k]) begin
        valid   = 1'b1;
        win[k]  = 1'b1;
        win_idx = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding fixed-length messages to one uart_tx, byte by byte.
// Optional `UART_ARB_CHKSUM_EN appends an 8-bit wrap-around sum byte to each message.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MSG_BYTES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*MSG_BYTES*8-1:0] msg_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic                           tx_start,
  output logic [7:0]                     tx_data,
  input  logic                           tx_rdy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned IDX_W = $clog2(MSG_BYTES + 1);
  localparam int unsigned MSG_W = MSG_BYTES * 8;
`ifdef UART_ARB_CHKSUM_EN
  localparam int unsigned TX_BYTES = MSG_BYTES + 1;
`else
  localparam int unsigned TX_BYTES = MSG_BYTES;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TX_BYTES - 1);

  arb_state_t         state, state_next;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_win;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   cur_idx;
  logic [MSG_W-1:0]   msg_buf;
  logic [MSG_W-1:0]   sel_msg;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   nidx;
  logic [7:0]         next_byte;
  logic               last_byte;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .valid   (pick_valid),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  always_comb begin
    sel_msg = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (pick_win[r]) sel_msg = msg_data[r*MSG_W +: MSG_W];
    end
  end

`ifdef UART_ARB_CHKSUM_EN
  logic [7:0] chksum;

  always_comb begin
    chksum = '0;
    for (int unsigned b = 0; b < MSG_BYTES; b++) begin
      chksum = chksum + msg_buf[b*8 +: 8];
    end
  end
`endif

  // The slot one past the payload carries the checksum when that feature is built in.
  always_comb begin
    nidx      = idx + IDX_W'(1);
    next_byte = '0;
    for (int unsigned b = 0; b < MSG_BYTES; b++) begin
      if (nidx == IDX_W'(b)) next_byte = msg_buf[b*8 +: 8];
    end
`ifdef UART_ARB_CHKSUM_EN
    if (nidx == IDX_W'(MSG_BYTES)) next_byte = chksum;
`endif
  end

  assign last_byte = (idx == LAST_IDX);
  assign busy      = (state != IDLE);
  assign tx_start  = (state == START) && tx_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = START;
      START:   if (tx_rdy)     state_next = WAIT_LO;
      WAIT_LO: if (!tx_rdy)    state_next = WAIT_HI;
      WAIT_HI: if (tx_rdy)     state_next = last_byte ? DONE : START;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      done    <= '0;
      tx_data <= '0;
      idx     <= '0;
      ptr     <= '0;
      cur_idx <= '0;
      msg_buf <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt     <= pick_win;
            cur_idx <= pick_idx;
            msg_buf <= sel_msg;
            idx     <= '0;
            tx_data <= sel_msg[7:0];
          end
        end
        WAIT_HI: begin
          if (tx_rdy) begin
            if (last_byte) begin
              done <= gnt;
            end else begin
              idx     <= nidx;
              tx_data <= next_byte;
            end
          end
        end
        DONE: begin
          gnt <= '0;
          ptr <= (cur_idx == PTR_W'(NUM_REQ - 1)) ? '0 : cur_idx + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a cycle-level uart_tx stand-in.
module tb_uart_tx_arbiter;

  localparam int unsigned NR    = 4;
  localparam int unsigned MB    = 2;
  localparam int          FRAME = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*MB*8-1:0] msg_data = '0;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic              busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_rdy;
  logic              stall = 1'b0;
  int                frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_byte[$];
  int         exp_req[$];
  int         exp_done[$];
  logic       prev_start = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .MSG_BYTES (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .msg_data (msg_data),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_rdy   (tx_rdy)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: busy for FRAME cycles starting the cycle after a strobe.
  always @(posedge clk) begin
    if (rst)                 frame_cnt <= 0;
    else if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
    else if (tx_start)       frame_cnt <= FRAME;
  end
  assign tx_rdy = (frame_cnt == 0) && !stall;

  always @(negedge clk) begin
    logic [7:0]    eb;
    logic [NR-1:0] eg;
    int            er;
    if (!rst) begin
      if (tx_start) begin
        checks++;
        if (prev_start) begin
          errors++;
          $display("FAIL strobe_width: tx_start high on consecutive cycles (got 1, need 0)");
        end
        if (exp_byte.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_start: tx_data=%h, no byte expected", tx_data);
        end else begin
          eb = exp_byte.pop_front();
          er = exp_req.pop_front();
          eg = NR'(1) << er;
          checks++;
          if (tx_data !== eb) begin
            errors++;
            $display("FAIL tx_data: got %h need %h", tx_data, eb);
          end
          checks++;
          if (gnt !== eg) begin
            errors++;
            $display("FAIL gnt_during_tx: got %b need %b", gnt, eg);
          end
        end
      end
      if (done !== '0) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got %b", done);
        end else begin
          er = exp_done.pop_front();
          eg = NR'(1) << er;
          checks++;
          if (done !== eg) begin
            errors++;
            $display("FAIL done_order: got %b need %b", done, eg);
          end
          checks++;
          if (exp_byte.size() != 0 && exp_req[0] == er) begin
            errors++;
            $display("FAIL done_early: got done with %0d bytes left, need 0", exp_byte.size());
          end
        end
      end
      prev_start = tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_msg(input int r, input logic [7:0] b0, input logic [7:0] b1);
    msg_data[r*MB*8 +: MB*8] = {b1, b0};
  endtask

  task automatic push_msg(input int r, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] s;
    exp_byte.push_back(b0); exp_req.push_back(r);
    exp_byte.push_back(b1); exp_req.push_back(r);
`ifdef UART_ARB_CHKSUM_EN
    s = b0 + b1;
    exp_byte.push_back(s); exp_req.push_back(r);
`else
    s = '0;
`endif
    exp_done.push_back(r);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; stall = 1'b0;
    exp_byte.delete(); exp_req.delete(); exp_done.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      req = req & ~done;
      if (!busy && req == '0) break;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles (busy=%b req=%b)", name, budget, busy, req);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== '0)      begin errors++; $display("FAIL reset_gnt: got %b need 0", gnt); end
    checks++; if (done !== '0)     begin errors++; $display("FAIL reset_done: got %b need 0", done); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b need 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h need 00", tx_data); end
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk); #1;
    set_msg(2, 8'hA5, 8'h3C);
    req = 4'b0100;
    push_msg(2, 8'hA5, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b need 0100", gnt); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL single_busy: got %b need 1", busy); end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_first_strobe: got %b need 1", tx_start); end
    run_until_idle(200, "single");
  endtask

  task automatic test_simultaneous();
    do_reset();
    @(posedge clk); #1;
    set_msg(0, 8'h01, 8'h02);
    set_msg(1, 8'h11, 8'h12);
    set_msg(3, 8'h31, 8'h32);
    req = 4'b1011;
    push_msg(0, 8'h01, 8'h02);
    push_msg(1, 8'h11, 8'h12);
    push_msg(3, 8'h31, 8'h32);
    run_until_idle(400, "simultaneous");
  endtask

  task automatic test_fairness();
    int n, nd;
    do_reset();
    @(posedge clk); #1;
    set_msg(0, 8'h40, 8'h41);
    set_msg(1, 8'h50, 8'h51);
    req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      push_msg(0, 8'h40, 8'h41);
      push_msg(1, 8'h50, 8'h51);
    end
    n = 0; nd = 0;
    while (n < 500) begin
      @(negedge clk);
      if (done !== '0) nd++;
      if (nd == 4) req = '0;
      if (nd >= 4 && !busy) break;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL fairness_timeout: %0d done pulses, need 4", nd);
    end
  endtask

  task automatic test_stall();
    int starts;
    do_reset();
    @(posedge clk); #1;
    stall = 1'b1;
    set_msg(3, 8'h77, 8'h88);
    req = 4'b1000;
    push_msg(3, 8'h77, 8'h88);
    starts = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL stall_strobe: got %0d strobes need 0", starts); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b need 1", busy); end
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL stall_release: got %b need 1", tx_start); end
    run_until_idle(200, "stall");
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    @(posedge clk); #1;
    set_msg(0, 8'hC3, 8'hD4);
    req = 4'b0001;
    push_msg(0, 8'hC3, 8'hD4);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (tx_start) break;
      n++;
    end
    checks++; if (n >= 50) begin errors++; $display("FAIL midreset_first_strobe: none within 50 cycles"); end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    exp_byte.delete(); exp_req.delete(); exp_done.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== '0)        begin errors++; $display("FAIL midreset_gnt: got %b need 0", gnt); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midreset_busy: got %b need 0", busy); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midreset_tx_start: got %b need 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midreset_tx_data: got %h need 00", tx_data); end
    for (int i = 0; i < 20; i++) @(negedge clk);
    @(posedge clk); #1;
    set_msg(1, 8'h9A, 8'hBC);
    req = 4'b0010;
    push_msg(1, 8'h9A, 8'hBC);
    run_until_idle(200, "midreset_next");
  endtask

  task automatic test_checksum();
    do_reset();
    @(posedge clk); #1;
    set_msg(0, 8'hF0, 8'h20);
    req = 4'b0001;
    push_msg(0, 8'hF0, 8'h20);
    run_until_idle(200, "checksum");
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_checksum();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_byte.size() != 0) begin
      errors++;
      $display("FAIL leftover_bytes: got %0d pending need 0", exp_byte.size());
    end
    checks++;
    if (exp_done.size() != 0) begin
      errors++;
      $display("FAIL leftover_done: got %0d pending need 0", exp_done.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
